// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The operands are resolved SEG bits per stage: 4-bit CLA groups joined by a
// group-lookahead unit, with the carry between segments registered.
// Optional feature: define CLA_PIPE_FLAGS_EN to build the ovf/zero flags;
// without it both flags are tied to 0.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned Stages = WIDTH / SEG;
  localparam int unsigned Groups = SEG / 4;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_in0;

  // Signals tapped from the last stage's combinational result
  logic             last_vld;
  logic [WIDTH-1:0] last_s;
  logic             last_c;
`ifdef CLA_PIPE_FLAGS_EN
  logic             last_cmsb;
`endif

  logic             out_vld_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c_in0 = cin ^ sub;

  // One global enable: every stage moves together or all hold, bubbles included
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
  end

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    localparam int unsigned Lo  = k * SEG;      // bits already resolved upstream
    localparam int unsigned Rem = WIDTH - Lo;   // operand bits still pending here

    logic [Rem-1:0]    op_a;
    logic [Rem-1:0]    op_b;
    logic              c_seg_in;
    logic              vld;
    logic [SEG-1:0]    p;
    logic [SEG-1:0]    g;
    logic [SEG-1:0]    sum;
    logic [SEG:0]      c;
    logic [Groups-1:0] grp_g;
    logic [Groups-1:0] grp_p;
    logic [Groups:0]   grp_c;
    logic [Lo+SEG-1:0] s_acc;

    if (k == 0) begin : g_first
      assign op_a     = a;
      assign op_b     = b_eff;
      assign c_seg_in = c_in0;
      assign vld      = in_valid;
      assign s_acc    = sum;
    end else begin : g_next
      logic [Rem-1:0] in_a_q;
      logic [Rem-1:0] in_b_q;
      logic [Lo-1:0]  in_s_q;
      logic           in_c_q;
      logic           in_vld_q;

      // Stage boundary: segment carry, finished low sum bits, pending operand bits
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_vld_q <= 1'b0;
          in_c_q   <= 1'b0;
          in_s_q   <= '0;
          in_a_q   <= '0;
          in_b_q   <= '0;
        end else if (advance) begin
          in_vld_q <= g_stage[k-1].vld;
          in_c_q   <= g_stage[k-1].c[SEG];
          in_s_q   <= g_stage[k-1].s_acc;
          in_a_q   <= g_stage[k-1].op_a[Rem+SEG-1:SEG];
          in_b_q   <= g_stage[k-1].op_b[Rem+SEG-1:SEG];
        end
      end

      assign op_a     = in_a_q;
      assign op_b     = in_b_q;
      assign c_seg_in = in_c_q;
      assign vld      = in_vld_q;
      assign s_acc    = {sum, in_s_q};
    end

    // Segment CLA: bit p/g, group G/P, group lookahead, then in-group carries
    always_comb begin
      p        = op_a[SEG-1:0] ^ op_b[SEG-1:0];
      g        = op_a[SEG-1:0] & op_b[SEG-1:0];
      grp_g    = '0;
      grp_p    = '0;
      grp_c    = '0;
      grp_c[0] = c_seg_in;
      for (int j = 0; j < Groups; j++) begin
        grp_p[j]   = &p[4*j +: 4];
        grp_g[j]   = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | ((&p[4*j+2 +: 2]) & g[4*j+1]) |
                     ((&p[4*j+1 +: 3]) & g[4*j]);
        grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
      c = '0;
      for (int j = 0; j < Groups; j++) begin
        c[4*j]   = grp_c[j];
        c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
        c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | ((&p[4*j +: 2]) & grp_c[j]);
        c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | ((&p[4*j+1 +: 2]) & g[4*j]) |
                   ((&p[4*j +: 3]) & grp_c[j]);
      end
      c[SEG] = grp_c[Groups];
      sum    = p ^ c[SEG-1:0];
    end

    if (k == Stages - 1) begin : g_last
      assign last_vld  = vld;
      assign last_s    = s_acc;
      assign last_c    = c[SEG];
`ifdef CLA_PIPE_FLAGS_EN
      assign last_cmsb = c[SEG-1];
`endif
    end
  end

  // Output register: all WIDTH bits of one beat appear together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      s_q       <= '0;
      cout_q    <= 1'b0;
    end else if (advance) begin
      out_vld_q <= last_vld;
      s_q       <= last_s;
      cout_q    <= last_c;
    end
  end

  assign out_valid = out_vld_q;
  assign s         = s_q;
  assign cout      = cout_q;

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // Flags ride in the output register next to the sum they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      ovf_q  <= last_cmsb ^ last_c;
      zero_q <= ~|last_s;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: a 32/8 instance takes directed beats,
// stalls and a mid-flight reset; a 16/4 instance takes a random stream.
module tb_cla_pipe_adder;

  localparam int unsigned NStages = 4;  // both instances have four stages

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  typedef struct {
    longint unsigned s;
    bit              cout;
    bit              ovf;
    bit              zero;
    int unsigned     edge_n;
    int unsigned     hold_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, iv0, ir0, cin0, sub0, ov0, or0, cout0, ovf0, zero0;
  logic [31:0] a0, b0, s0;
  logic        rst1_n, iv1, ir1, cin1, sub1, ov1, or1, cout1, ovf1, zero1;
  logic [15:0] a1, b1, s1;

  cla_pipe_adder #(.WIDTH(32), .SEG(8)) dut0 (
    .clk(clk), .rst_n(rst0_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .s(s0), .cout(cout0),
    .ovf(ovf0), .zero(zero0)
  );

  cla_pipe_adder #(.WIDTH(16), .SEG(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .s(s1), .cout(cout1),
    .ovf(ovf1), .zero(zero1)
  );

  int          errors = 0;
  int          checks = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned edge_cnt[2];
  int unsigned hold_cnt[2];
  bit          seen[2];
  bit          held[2];
  logic [35:0] snap[2];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(input int unsigned w, input longint unsigned av,
                                 input longint unsigned bv, input bit c, input bit sb);
    exp_t   e;
    longint m, half, sa, sb_s, r, sr, ci;
    m    = longint'(1) << w;
    half = m >> 1;
    ci   = longint'(c);
    sa   = (longint'(av) >= half) ? longint'(av) - m : longint'(av);
    sb_s = (longint'(bv) >= half) ? longint'(bv) - m : longint'(bv);
    if (!sb) begin
      r      = longint'(av) + longint'(bv) + ci;
      sr     = sa + sb_s + ci;
      e.cout = (r >= m);
    end else begin
      r      = longint'(av) - longint'(bv) - ci;
      sr     = sa - sb_s - ci;
      e.cout = (r >= 0);  // no borrow
    end
    e.s      = longint'(r) & (m - 1);
    e.ovf    = (sr >= half) || (sr < -half);
    e.zero   = (e.s == 0);
    e.edge_n = 0;
    e.hold_n = 0;
    return e;
  endfunction

  task automatic beat0(input bit v, input logic [31:0] av, input logic [31:0] bv, input bit c,
                       input bit sb, input bit rdy, output bit acc);
    exp_t e;
    @(negedge clk);
    iv0 = v; a0 = av; b0 = bv; cin0 = c; sub0 = sb; or0 = rdy;
    #1;
    acc = iv0 && ir0;
    if (acc) begin
      e        = model(32, av, bv, c, sb);
      e.edge_n = edge_cnt[0] + 1;
      e.hold_n = hold_cnt[0];
      q0.push_back(e);
    end
  endtask

  task automatic beat1(input bit v, input logic [15:0] av, input logic [15:0] bv, input bit c,
                       input bit sb, input bit rdy, output bit acc);
    exp_t e;
    @(negedge clk);
    iv1 = v; a1 = av; b1 = bv; cin1 = c; sub1 = sb; or1 = rdy;
    #1;
    acc = iv1 && ir1;
    if (acc) begin
      e        = model(16, av, bv, c, sb);
      e.edge_n = edge_cnt[1] + 1;
      e.hold_n = hold_cnt[1];
      q1.push_back(e);
    end
  endtask

  task automatic drain0();
    bit acc;
    for (int i = 0; i < 40 && q0.size() != 0; i++) beat0(0, 0, 0, 0, 0, 1, acc);
    if (q0.size() != 0) chk("drain0_timeout", q0.size(), 0);
  endtask

  task automatic drain1();
    bit acc;
    for (int i = 0; i < 40 && q1.size() != 0; i++) beat1(0, 0, 0, 0, 0, 1, acc);
    if (q1.size() != 0) chk("drain1_timeout", q1.size(), 0);
  endtask

  // One monitor sample per cycle, taken late in the low phase
  task automatic mon_step(input int d);
    bit          v, r, rdy, have;
    logic [35:0] obs;
    exp_t        e;
    if (d == 0) begin
      if (!rst0_n) return;
      v = ov0; r = ir0; rdy = or0;
      obs  = {ov0, cout0, ovf0, zero0, s0};
      have = (q0.size() != 0);
      if (have) e = q0[0];
    end else begin
      if (!rst1_n) return;
      v = ov1; r = ir1; rdy = or1;
      obs  = {ov1, cout1, ovf1, zero1, 16'h0, s1};
      have = (q1.size() != 0);
      if (have) e = q1[0];
    end
    chk($sformatf("in_ready[%0d]", d), r, !v || rdy);
    if (held[d]) chk($sformatf("stall_hold[%0d]", d), obs, snap[d]);
    if (v) begin
      if (!have) begin
        chk($sformatf("spurious_out_valid[%0d]", d), 1, 0);
      end else begin
        if (!seen[d]) begin
          chk($sformatf("latency[%0d]", d), edge_cnt[d] - e.edge_n,
              NStages - 1 + hold_cnt[d] - e.hold_n);
          seen[d] = 1'b1;
        end
        if (rdy) begin
          chk($sformatf("s[%0d]", d), obs[31:0], e.s);
          chk($sformatf("cout[%0d]", d), obs[34], e.cout);
          chk($sformatf("ovf[%0d]", d), obs[33], FlagsOn && e.ovf);
          chk($sformatf("zero[%0d]", d), obs[32], FlagsOn && e.zero);
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
          seen[d] = 1'b0;
        end
      end
    end
    held[d] = v && !rdy;
    snap[d] = obs;
    edge_cnt[d]++;
    if (!r) hold_cnt[d]++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      mon_step(0);
      mon_step(1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit          acc;
    int          sent;
    logic [15:0] ra, rb;
    for (int d = 0; d < 2; d++) begin
      edge_cnt[d] = 0; hold_cnt[d] = 0; seen[d] = 1'b0; held[d] = 1'b0; snap[d] = '0;
    end
    iv0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
    rst0_n = 1; rst1_n = 1;
    #1;
    rst0_n = 0; rst1_n = 0;
    #1;
    chk("rst_out_valid0", ov0, 0);
    chk("rst_s0", s0, 0);
    chk("rst_cout0", cout0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_zero0", zero0, 0);
    chk("rst_in_ready0", ir0, 1);
    chk("rst_out_valid1", ov1, 0);
    chk("rst_in_ready1", ir1, 1);
    repeat (2) @(negedge clk);
    #2;
    rst0_n = 1; rst1_n = 1;

    // Directed beats: wrap to zero, subtract with/without borrow-in, overflow
    beat0(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, acc);
    beat0(1, 32'h5, 32'h7, 0, 1, 1, acc);
    beat0(1, 32'h5, 32'h7, 1, 1, 1, acc);
    beat0(1, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, acc);
    beat0(1, 32'h8000_0000, 32'h1, 0, 1, 1, acc);
    drain0();

    // Eight back-to-back beats, consumer stalls for three cycles mid-stream
    sent = 0;
    for (int i = 0; i < 40 && (sent < 8 || i < 12); i++) begin
      beat0(sent < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            !(i >= 5 && i <= 7), acc);
      if (acc) sent++;
    end
    chk("burst_sent", sent, 8);
    drain0();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      beat0(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, acc);
    beat0(0, 0, 0, 0, 0, 1, acc);
    @(posedge clk);
    #2;
    chk("pre_reset_out_valid", ov0, 1);
    rst0_n = 0;
    #1;
    chk("mid_reset_out_valid", ov0, 0);
    chk("mid_reset_s", s0, 0);
    chk("mid_reset_in_ready", ir0, 1);
    q0.delete();
    seen[0] = 1'b0;
    held[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst0_n = 1;
    repeat (8) beat0(0, 0, 0, 0, 0, 1, acc);
    beat0(1, 32'h1234_5678, 32'h0FED_CBA9, 1, 0, 1, acc);
    drain0();

    // Random stream on the 16-bit, 4-bit-segment instance
    sent = 0;
    for (int i = 0; i < 20000 && sent < 1000; i++) begin
      ra = pick16();
      rb = pick16();
      beat1($urandom_range(0, 9) < 8, ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
      if (acc) sent++;
    end
    chk("random_sent", sent, 1000);
    drain1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
